lc3b_mem_ctrl: RTL and testbench
================================

// Module: lc3b_mem_ctrl
// PURPOSE
//  Memory-access controller between the MAR/MDR datapath and the LC-3b unified memory.
//  Takes one load/store request at a time (word or byte), drives the memory port until
//  the memory ready (R) strobe, steers byte lanes, and returns one response to the MDR.
//  Raises an error instead of accessing memory on a misaligned word access or a timeout.
// PARAMETERS
//  TIMEOUT   255  max cycles in ACCESS without mem_r before aborting with error (1..255)
// PORTS
//  clk         in   1   single clock; all state changes on posedge
//  rst_n       in   1   synchronous, active-low reset
//  req_valid   in   1   request strobe from control path
//  req_ready   out  1   controller idle, request accepted this cycle if req_valid=1
//  req_we      in   1   1=store, 0=load
//  req_byte    in   1   1=byte access (LDB/STB), 0=word access
//  req_addr    in   16  byte address from MAR
//  req_wdata   in   16  store data from DR; byte stores use [7:0]
//  resp_valid  out  1   one-cycle pulse: response fields valid
//  resp_rdata  out  16  load data to MDR; byte loads zero-extended (SEXT done downstream)
//  resp_err    out  1   qualifies resp_valid: misaligned word or timeout
//  mem_en      out  1   memory enable, held until mem_r
//  mem_we      out  2   byte write enables {hi,lo}; 2'b00 on loads
//  mem_addr    out  16  word-aligned address {req_addr[15:1],1'b0}
//  mem_wdata   out  16  write data
//  mem_rdata   in   16  read data, valid when mem_r=1
//  mem_r       in   1   memory ready; completes the access
// BEHAVIOUR
//  - All outputs registered except req_ready (=state==IDLE && rst_n). On rst_n=0 at posedge:
//    state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0,
//    mem_wdata=0, timeout counter=0.
//  - States: IDLE -> ACCESS -> RESP -> IDLE; IDLE -> RESP on misaligned word.
//  - IDLE: on req_valid latch we/byte/addr/wdata. If !req_byte && req_addr[0]: go RESP with
//    resp_err=1, resp_rdata=0, no memory cycle. Else go ACCESS; mem_en=1 from next cycle.
//  - ACCESS: mem_en, mem_we, mem_addr, mem_wdata held stable. Counter increments each
//    cycle. On mem_r=1: capture read data, drop mem_en/mem_we next edge, go RESP, err=0.
//    If counter reaches TIMEOUT with mem_r=0: drop mem_en, go RESP, err=1, rdata=0.
//    mem_r and timeout in same cycle: mem_r wins (normal completion).
//  - RESP: resp_valid=1 exactly one cycle, then IDLE; counter cleared.
//  - Byte lanes (little-endian, odd byte = [15:8]): word store we=2'b11, wdata=req_wdata;
//    byte store we = addr[0] ? 2'b10 : 2'b01, wdata={req_wdata[7:0],req_wdata[7:0]};
//    word load rdata=mem_rdata; byte load rdata={8'h00, addr[0]?mem_rdata[15:8]:[7:0]}.
//  - Latency: accept at edge N, mem_en high from N+1; mem_r sampled at edge N+1+k ->
//    resp_valid high the following cycle. Min request-to-response: 2 cycles after accept.
//  - req_valid while not IDLE ignored (req_ready=0); no queueing. mem_r outside ACCESS
//    ignored. resp_rdata/resp_err hold last value after RESP until next response.
//  - Reset mid-ACCESS: access abandoned, mem_en low after the reset edge, no response.
// STRUCTURE
//  - Package lc3b_mem_pkg: state enum {IDLE,ACCESS,RESP}, byte-enable constants
//    BE_NONE/BE_LO/BE_HI/BE_WORD, default TIMEOUT.
//  - Sub-module lc3b_mem_lane (combinational): write-data replication, byte-enable
//    generation, read-lane extraction; FSM and counter stay in lc3b_mem_ctrl.
// TESTING
//  - Word load addr 16'h3000, mem_r after 3 cycles, mem_rdata=16'hBEEF -> mem_addr=16'h3000,
//    mem_we=00, resp_rdata=16'hBEEF, resp_err=0, resp_valid one cycle.
//  - Byte store addr 16'h4001, wdata 16'h12A5 -> mem_addr=16'h4000, mem_we=2'b10,
//    mem_wdata=16'hA5A5; byte load 16'h4001, mem_rdata=16'hA534 -> resp_rdata=16'h00A5.
//  - Word load addr 16'h4001 -> no mem_en ever, resp_valid+resp_err next-but-one cycle, rdata=0.
//  - mem_r never asserted, TIMEOUT=8 -> mem_en drops after 8 ACCESS cycles, resp_err=1;
//    repeat with mem_r on the 8th cycle -> resp_err=0.
//  - rst_n=0 during ACCESS -> mem_en=0 next edge, no resp_valid; next request served normally.
//  - req_valid held high through an access, mem_r pulsed in IDLE -> only one response,
//    second request accepted only in the cycle after RESP.

Source files
------------

// File: rtl/lc3b_mem_pkg.sv
// Shared types and constants for the LC-3b memory-access controller.
package lc3b_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Byte write enables {hi, lo}; the odd byte of a word lives in [15:8].
    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int CNT_W           = 8;

    function automatic logic [15:0] word_align(input logic [15:0] addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/lc3b_mem_ctrl_if.sv
// Request/response bus from the MAR/MDR datapath plus the unified memory port.
// master = datapath/memory side, slave = the controller.
interface lc3b_mem_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;

    logic        mem_en;
    logic [1:0]  mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_r;

    modport master (
        output req_valid, req_we, req_byte, req_addr, req_wdata, mem_rdata, mem_r,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_addr, req_wdata, mem_rdata, mem_r,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lc3b_mem_lane.sv
// Byte-lane steering: store data replication, byte enables, load lane extraction.
module lc3b_mem_lane
    import lc3b_mem_pkg::*;
(
    input  logic        wr_we,
    input  logic        wr_byte,
    input  logic        wr_addr0,
    input  logic [15:0] wr_data,
    output logic [1:0]  wr_be,
    output logic [15:0] wr_data_lane,
    input  logic        rd_byte,
    input  logic        rd_addr0,
    input  logic [15:0] rd_data,
    output logic [15:0] rd_data_lane
);

    // Byte stores put the low byte on both lanes and enable only the addressed one;
    // byte loads return the addressed lane zero-extended.
    always_comb begin
        wr_be = BE_NONE;
        if (wr_we) begin
            if (wr_byte) begin
                wr_be = wr_addr0 ? BE_HI : BE_LO;
            end else begin
                wr_be = BE_WORD;
            end
        end
        wr_data_lane = wr_byte ? {wr_data[7:0], wr_data[7:0]} : wr_data;
        if (rd_byte) begin
            rd_data_lane = {8'h00, rd_addr0 ? rd_data[15:8] : rd_data[7:0]};
        end else begin
            rd_data_lane = rd_data;
        end
    end

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// Memory-access controller between the MAR/MDR datapath and LC-3b unified memory.
//
//  state  | meaning
//  -------+-----------------------------------------------------------------
//  IDLE   | ready for a request; misaligned word goes straight to RESP
//  ACCESS | memory port driven, waiting for mem_r or timeout
//  RESP   | result held internally; resp_* registered out on leaving RESP
module lc3b_mem_ctrl
    import lc3b_mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst_n,
    lc3b_mem_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               byte_q, byte_d;
    logic               addr0_q, addr0_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               resp_valid_d, resp_err_d, mem_en_d;
    logic [15:0]        resp_rdata_d, mem_addr_d, mem_wdata_d;
    logic [1:0]         mem_we_d;

    logic [1:0]         lane_be;
    logic [15:0]        lane_wdata, lane_rdata;

    assign bus.req_ready = (state_q == IDLE) && rst_n;
    assign cnt_inc       = cnt_q + 1'b1;

    lc3b_mem_lane u_lane (
        .wr_we        (bus.req_we),
        .wr_byte      (bus.req_byte),
        .wr_addr0     (bus.req_addr[0]),
        .wr_data      (bus.req_wdata),
        .wr_be        (lane_be),
        .wr_data_lane (lane_wdata),
        .rd_byte      (byte_q),
        .rd_addr0     (addr0_q),
        .rd_data      (bus.mem_rdata),
        .rd_data_lane (lane_rdata)
    );

    // Next-state and next-output logic; every register holds unless a state changes it.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        addr0_d      = addr0_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = bus.resp_rdata;
        resp_err_d   = bus.resp_err;
        mem_en_d     = bus.mem_en;
        mem_we_d     = bus.mem_we;
        mem_addr_d   = bus.mem_addr;
        mem_wdata_d  = bus.mem_wdata;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req_valid) begin
                    byte_d  = bus.req_byte;
                    addr0_d = bus.req_addr[0];
                    if (!bus.req_byte && bus.req_addr[0]) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d     = ACCESS;
                        mem_en_d    = 1'b1;
                        mem_we_d    = lane_be;
                        mem_addr_d  = word_align(bus.req_addr);
                        mem_wdata_d = lane_wdata;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_inc;
                // mem_r takes priority over a timeout landing in the same cycle.
                if (bus.mem_r) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = BE_NONE;
                    rdata_d  = lane_rdata;
                    err_d    = 1'b0;
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = BE_NONE;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                end
            end
            RESP: begin
                state_d      = IDLE;
                cnt_d        = '0;
                resp_valid_d = 1'b1;
                resp_rdata_d = rdata_q;
                resp_err_d   = err_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, timeout counter and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            byte_q         <= 1'b0;
            addr0_q        <= 1'b0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= BE_NONE;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            byte_q         <= byte_d;
            addr0_q        <= addr0_d;
            rdata_q        <= rdata_d;
            err_q          <= err_d;
            bus.resp_valid <= resp_valid_d;
            bus.resp_rdata <= resp_rdata_d;
            bus.resp_err   <= resp_err_d;
            bus.mem_en     <= mem_en_d;
            bus.mem_we     <= mem_we_d;
            bus.mem_addr   <= mem_addr_d;
            bus.mem_wdata  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Directed bench for lc3b_mem_ctrl with a response scoreboard (TIMEOUT = 8).
module tb_lc3b_mem_ctrl;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        bit          chk_rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   resp_cnt = 0;
    int   lat;
    exp_t exp_q[$];

    lc3b_mem_ctrl_if bus ();

    lc3b_mem_ctrl #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic err, input logic [15:0] rdata, input bit chk_rd);
        exp_t e;
        e.err = err; e.rdata = rdata; e.chk_rd = chk_rd;
        exp_q.push_back(e);
        n_pushed++;
    endtask

    // Drive one request for a single accepting edge, then drop req_valid.
    task automatic issue(input logic we, input logic bt, input logic [15:0] addr,
                         input logic [15:0] wdata);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_byte = bt;
        bus.req_addr = addr;  bus.req_wdata = wdata;
        tick();
        bus.req_valid = 1'b0;
    endtask

    // Bounded wait for resp_valid; lat = edges waited, 0 if the budget ran out.
    task automatic wait_resp(input int budget, output int cycles);
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.resp_valid === 1'b1) begin
                cycles = i;
                return;
            end
        end
    endtask

    // Scoreboard: every response pulse is popped and compared.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.resp_valid === 1'b1) begin
            resp_cnt++;
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL resp_unexpected: observed rdata %h err %b expected no response",
                       bus.resp_rdata, bus.resp_err);
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_err", 32'(bus.resp_err), 32'(e.err));
                if (e.chk_rd) chk("sb_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_byte = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.mem_rdata = '0; bus.mem_r = 1'b0;
        tick(); tick();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mem_en",    32'(bus.mem_en),    32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_resp_valid",32'(bus.resp_valid),32'd0);
        chk("rst_resp_rdata",32'(bus.resp_rdata),32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Word load, mem_r on the third ACCESS cycle.
        push(1'b0, 16'hBEEF, 1'b1);
        issue(1'b0, 1'b0, 16'h3000, 16'h0000);
        chk("wl_mem_en",    32'(bus.mem_en),    32'd1);
        chk("wl_mem_addr",  32'(bus.mem_addr),  32'h3000);
        chk("wl_mem_we",    32'(bus.mem_we),    32'd0);
        chk("wl_req_ready", 32'(bus.req_ready), 32'd0);
        tick(); tick();
        chk("wl_mem_en_hold", 32'(bus.mem_en), 32'd1);
        bus.mem_r = 1'b1; bus.mem_rdata = 16'hBEEF;
        tick();
        bus.mem_r = 1'b0; bus.mem_rdata = 16'h0000;
        chk("wl_mem_en_drop", 32'(bus.mem_en),     32'd0);
        chk("wl_no_early",    32'(bus.resp_valid), 32'd0);
        wait_resp(10, lat);
        chk("wl_latency",   32'(lat),             32'd1);
        chk("wl_rdata",     32'(bus.resp_rdata),  32'hBEEF);
        tick();
        chk("wl_one_cycle", 32'(bus.resp_valid),  32'd0);
        chk("wl_hold",      32'(bus.resp_rdata),  32'hBEEF);

        // Byte store to the odd byte.
        push(1'b0, 16'h0000, 1'b0);
        issue(1'b1, 1'b1, 16'h4001, 16'h12A5);
        chk("bs_mem_addr",  32'(bus.mem_addr),  32'h4000);
        chk("bs_mem_we",    32'(bus.mem_we),    32'h2);
        chk("bs_mem_wdata", 32'(bus.mem_wdata), 32'hA5A5);
        bus.mem_r = 1'b1; bus.mem_rdata = 16'h7777;
        tick();
        bus.mem_r = 1'b0;
        chk("bs_mem_we_drop", 32'(bus.mem_we), 32'd0);
        wait_resp(10, lat);
        chk("bs_latency", 32'(lat), 32'd1);

        // Byte store to the even byte, word store.
        push(1'b0, 16'h0000, 1'b0);
        issue(1'b1, 1'b1, 16'h4000, 16'h0F3C);
        chk("bs0_mem_we",    32'(bus.mem_we),    32'h1);
        chk("bs0_mem_wdata", 32'(bus.mem_wdata), 32'h3C3C);
        bus.mem_r = 1'b1; tick(); bus.mem_r = 1'b0;
        wait_resp(10, lat);
        push(1'b0, 16'h0000, 1'b0);
        issue(1'b1, 1'b0, 16'h5002, 16'h1234);
        chk("ws_mem_we",    32'(bus.mem_we),    32'h3);
        chk("ws_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
        chk("ws_mem_addr",  32'(bus.mem_addr),  32'h5002);
        bus.mem_r = 1'b1; tick(); bus.mem_r = 1'b0;
        wait_resp(10, lat);

        // Byte loads from both lanes.
        push(1'b0, 16'h00A5, 1'b1);
        issue(1'b0, 1'b1, 16'h4001, 16'h0000);
        chk("bl1_mem_addr", 32'(bus.mem_addr), 32'h4000);
        chk("bl1_mem_we",   32'(bus.mem_we),   32'd0);
        bus.mem_r = 1'b1; bus.mem_rdata = 16'hA534; tick(); bus.mem_r = 1'b0;
        wait_resp(10, lat);
        chk("bl1_rdata", 32'(bus.resp_rdata), 32'h00A5);
        push(1'b0, 16'h0034, 1'b1);
        issue(1'b0, 1'b1, 16'h4000, 16'h0000);
        tick();
        bus.mem_r = 1'b1; bus.mem_rdata = 16'hA534; tick(); bus.mem_r = 1'b0;
        wait_resp(10, lat);
        chk("bl0_rdata", 32'(bus.resp_rdata), 32'h0034);

        // Misaligned word load: no memory cycle, error response next-but-one cycle.
        push(1'b1, 16'h0000, 1'b1);
        issue(1'b0, 1'b0, 16'h4001, 16'h0000);
        chk("mis_mem_en",   32'(bus.mem_en),     32'd0);
        chk("mis_no_early", 32'(bus.resp_valid), 32'd0);
        wait_resp(10, lat);
        chk("mis_latency",  32'(lat),             32'd1);
        chk("mis_mem_en2",  32'(bus.mem_en),      32'd0);
        chk("mis_err",      32'(bus.resp_err),    32'd1);
        chk("mis_rdata",    32'(bus.resp_rdata),  32'd0);

        // Timeout: mem_r never arrives.
        push(1'b1, 16'h0000, 1'b1);
        issue(1'b0, 1'b0, 16'h6000, 16'h0000);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("to_mem_en_hold", 32'(bus.mem_en), 32'd1);
        end
        tick();
        chk("to_mem_en_drop", 32'(bus.mem_en), 32'd0);
        wait_resp(10, lat);
        chk("to_latency", 32'(lat),          32'd1);
        chk("to_err",     32'(bus.resp_err), 32'd1);

        // mem_r on the last allowed cycle completes normally.
        push(1'b0, 16'hCAFE, 1'b1);
        issue(1'b0, 1'b0, 16'h6002, 16'h0000);
        for (int i = 1; i <= 7; i++) tick();
        chk("to8_mem_en_hold", 32'(bus.mem_en), 32'd1);
        bus.mem_r = 1'b1; bus.mem_rdata = 16'hCAFE; tick(); bus.mem_r = 1'b0;
        wait_resp(10, lat);
        chk("to8_err",   32'(bus.resp_err),   32'd0);
        chk("to8_rdata", 32'(bus.resp_rdata), 32'hCAFE);

        // Reset in the middle of ACCESS abandons the access.
        issue(1'b0, 1'b0, 16'h7000, 16'h0000);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rma_mem_en",    32'(bus.mem_en),    32'd0);
        chk("rma_req_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b1;
        bus.mem_r = 1'b1; tick(); bus.mem_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rma_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        push(1'b0, 16'h5A5A, 1'b1);
        issue(1'b0, 1'b0, 16'h7002, 16'h0000);
        chk("rma_next_en", 32'(bus.mem_en), 32'd1);
        bus.mem_r = 1'b1; bus.mem_rdata = 16'h5A5A; tick(); bus.mem_r = 1'b0;
        wait_resp(10, lat);
        chk("rma_next_latency", 32'(lat), 32'd1);

        // req_valid held high across an access, mem_r pulsed in IDLE.
        push(1'b0, 16'h1111, 1'b1);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_byte = 1'b0;
        bus.req_addr = 16'h8000;
        tick();
        chk("hold_req_ready_acc", 32'(bus.req_ready), 32'd0);
        bus.mem_r = 1'b1; bus.mem_rdata = 16'h1111; tick(); bus.mem_r = 1'b0;
        chk("hold_req_ready_resp", 32'(bus.req_ready), 32'd0);
        push(1'b0, 16'h00AB, 1'b1);
        bus.req_byte = 1'b1; bus.req_addr = 16'h8001;
        tick();
        chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("hold_req_ready",  32'(bus.req_ready),  32'd1);
        chk("hold_no_accept",  32'(bus.mem_en),     32'd0);
        bus.mem_r = 1'b1;
        tick();
        bus.req_valid = 1'b0; bus.mem_r = 1'b0;
        chk("hold2_mem_en",   32'(bus.mem_en),     32'd1);
        chk("hold2_no_resp",  32'(bus.resp_valid), 32'd0);
        tick();
        chk("hold2_mem_en2",  32'(bus.mem_en),     32'd1);
        chk("hold2_no_resp2", 32'(bus.resp_valid), 32'd0);
        bus.mem_r = 1'b1; bus.mem_rdata = 16'hABCD; tick(); bus.mem_r = 1'b0;
        wait_resp(10, lat);
        chk("hold2_rdata", 32'(bus.resp_rdata), 32'h00AB);
        tick(); tick();

        chk("sb_empty",     32'(exp_q.size()), 32'd0);
        chk("resp_count",   32'(resp_cnt),     32'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
